// File: rtl/dot_matrix_scanner.sv
// Drives an 8x16 LED dot matrix from a 16-step history of 3-bit lane words.
// Rows are scanned one at a time; column 0 shows the newest word.
module dot_matrix_scanner #(
   parameter logic [31:0] SCAN_DIV = 32'd25000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        step,
   input  logic [2:0]  lane_in,
   output logic [7:0]  dot_row,
   output logic [15:0] dot_col
);

   logic        r_s1;
   logic        r_s2;
   logic        r_s3;
   logic        w_step_rise;
   logic [2:0]  r_frame [16];
   logic [31:0] r_scan_cnt;
   logic [2:0]  r_row_idx;
   logic        w_row_adv;
   logic [15:0] w_col;
   logic [7:0]  r_dot_row;
   logic [15:0] r_dot_col;

   // Lane bit shown on a given row; rows 2 and 5 are blank separators.
   function automatic logic lit(input logic [2:0] row, input logic [2:0] word);
      logic l;
      case (row)
         3'd0, 3'd1: l = word[2];
         3'd3, 3'd4: l = word[1];
         3'd6, 3'd7: l = word[0];
         default:    l = 1'b0;
      endcase
      return l;
   endfunction

   // step is asynchronous to clk; s3 only serves edge detection.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= step;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_step_rise = r_s2 & ~r_s3;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < 16; k++) r_frame[k] <= 3'b000;
      end else if (w_step_rise) begin
         r_frame[0] <= lane_in;
         for (int k = 1; k < 16; k++) r_frame[k] <= r_frame[k-1];
      end
   end

   assign w_row_adv = (r_scan_cnt == (SCAN_DIV - 32'd1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_scan_cnt <= 32'd0;
         r_row_idx  <= 3'd0;
      end else if (w_row_adv) begin
         r_scan_cnt <= 32'd0;
         r_row_idx  <= r_row_idx + 3'd1;
      end else begin
         r_scan_cnt <= r_scan_cnt + 32'd1;
      end
   end

   always_comb begin
      w_col = 16'hFFFF;
      for (int c = 0; c < 16; c++) w_col[c] = ~lit(r_row_idx, r_frame[c]);
   end

   // Output stage: pins lag row_idx/frame by one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_dot_row <= 8'h00;
         r_dot_col <= 16'hFFFF;
      end else begin
         r_dot_row <= 8'b1 << r_row_idx;
         r_dot_col <= w_col;
      end
   end

   assign dot_row = r_dot_row;
   assign dot_col = r_dot_col;

endmodule

// File: doc/dot_matrix_scanner.md
# dot_matrix_scanner

Display back-end for the falling-tile game. It keeps a 16-step history of the 3-bit lane word produced by the tile shifter and captures one new word per rising edge of the slow step clock. It time-multiplexes that history onto an 8-row by 16-column LED dot matrix, one row at a time. It sits directly downstream of the tile shifter's `data_now[0]` output and drives the board's `dot_row`/`dot_col` pins.

## Interface
Parameters:
- `SCAN_DIV`, default 25000: number of `clk` cycles each row stays lit. Legal range 1..2^32-1.

Ports:
- `clk`  in  1  system clock (50 MHz on board).
- `rst`  in  1  asynchronous, active-low reset.
- `step`  in  1  slow step clock from the divider (1 Hz on board), asynchronous to `clk`.
- `lane_in`  in  3  newest lane word; bit2 = lane A, bit1 = lane B, bit0 = lane C; 1 = tile present.
- `dot_row`  out  8  row select, one-hot, active-high.
- `dot_col`  out  16  column drive, active-low (0 = LED on).

## Operation
- **Step capture**
  - `step` passes through a 2-FF synchronizer (`s1`, `s2`), then a delay register `s3`.
  - `step_rise = s2 & ~s3`.
- **History buffer**
  - `frame[0..15]`, 3 bits each.
  - On `step_rise`: `frame[0] <= lane_in`, and `frame[k] <= frame[k-1]` for k = 1..15. `frame[15]` is discarded.
  - `lane_in` is sampled in the `step_rise` cycle. The upstream word has already settled by then.
- **Row scan**
  - 32-bit counter `scan_cnt` counts 0..SCAN_DIV-1.
  - At `SCAN_DIV-1`, `scan_cnt` returns to 0 and 3-bit `row_idx` increments. `row_idx` wraps 7 -> 0.
  - With `SCAN_DIV = 1`, `row_idx` advances every cycle.
- **Row-to-lane map**
  - Rows 0–1 = lane A (bit2).
  - Row 2 = gap.
  - Rows 3–4 = lane B (bit1).
  - Row 5 = gap.
  - Rows 6–7 = lane C (bit0).
- **Output registers**, updated every `clk` cycle:
  - `dot_row <= 1 << row_idx`.
  - `dot_col[c] <= ~lit(row_idx, frame[c])` for c = 0..15. Column 0 shows the newest word; column 15 shows the oldest.
  - In gap rows, `lit` = 0, so all columns read 1.
- **Simultaneous events**: if `step_rise` and a row advance fall in the same cycle, both take effect. The next output update uses the new row and the shifted frame.
- **No handshake.** Upstream never stalls. A `step` pulse shorter than 2 `clk` periods may be missed; that is not supported.

## Timing
- **Reset (asynchronous, immediate)**
  - `dot_row = 8'h00`, `dot_col = 16'hFFFF`.
  - `frame[*] = 0`, `row_idx = 0`, `scan_cnt = 0`, `s1 = s2 = s3 = 0`.
- **First clock after reset release**: `dot_row = 8'h01`, `dot_col = 16'hFFFF`.
- **Step to frame latency**: a `step` rising edge at clock-edge N (setup met) gives `s2 = 1` at N+2. That is the `step_rise` cycle, and `frame[0]` updates at that edge. Pins reflect the change at N+3.
- **Row dwell**: exactly `SCAN_DIV` cycles per row. Full refresh period is `8*SCAN_DIV` cycles.
- **Output latency**: pins lag `row_idx`/`frame` by one register stage (1 cycle).
- **Reset mid-scan** clears all state at once. Scanning restarts at row 0 with an empty frame.

## Test plan
All scenarios use `SCAN_DIV = 4`.
1. **Reset values**: assert `rst = 0` mid-scan -> `dot_row = 8'h00` and `dot_col = 16'hFFFF` in the same cycle. After release -> `dot_row = 8'h01` at the next edge.
2. **Row cycling**: no steps -> `dot_row` steps 01, 02, 04 … 80, 01, each value held exactly 4 cycles. `dot_col` stays `16'hFFFF` throughout.
3. **Single word**:
   - Stimulus: `lane_in = 3'b100`, one `step` pulse lasting 10 cycles.
   - Rows 0–1 -> `dot_col = 16'hFFFE`.
   - Rows 2–7 -> `dot_col = 16'hFFFF`.
   - The update appears 3 cycles after the `step` edge.
4. **Shift and discard**:
   - Stimulus: `lane_in = 3'b001` for the first step, then 16 more steps with `lane_in = 0`.
   - After the 2nd step -> rows 6–7 show `dot_col = 16'hFFFD`.
   - After the 16th step -> rows 6–7 show `dot_col = 16'h7FFF`.
   - After the 17th step -> `16'hFFFF`.
5. **Simultaneous events**: align `step_rise` with the terminal `scan_cnt` cycle -> the next output shows both the new row and the shifted frame, with no skipped row.
6. **Full pattern**: 16 steps of `lane_in = 3'b111` -> rows 0, 1, 3, 4, 6, 7 give `dot_col = 16'h0000`. Rows 2 and 5 give `16'hFFFF`.
